// File: rtl/x_in_serializer_pkg.sv
// Shared definitions for the x_in serializer: FSM encoding and default geometry.
package x_in_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_HOLD  = 3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/x_in_serializer_bit_hold_counter.sv
// Times how long the current bit stays on x_in; expired marks the last hold cycle.
module bit_hold_counter
   import x_in_serializer_pkg::*;
#(
   parameter int HOLD = DEFAULT_HOLD
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic expired
);

   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt_r;
   logic          active_r;

   // start re-arms the counter; without a new start it stops after the last hold cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (start) begin
         cnt_r    <= '0;
         active_r <= 1'b1;
      end else if (active_r) begin
         if (expired) begin
            cnt_r    <= '0;
            active_r <= 1'b0;
         end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            active_r <= 1'b1;
         end
      end else begin
         cnt_r    <= cnt_r;
         active_r <= active_r;
      end
   end

   assign expired = active_r && (cnt_r == LAST_CNT);

endmodule

// File: rtl/x_in_serializer.sv
// Serializes a WIDTH-bit pattern MSB first onto x_in, each bit held HOLD cycles,
// with a ready/valid load port that allows gapless back-to-back patterns.
module x_in_serializer
   import x_in_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int HOLD  = DEFAULT_HOLD
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             x_in,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   logic [0:0]       state_r;
   logic [0:0]       state_nx_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nx_s;
   logic [BW-1:0]    bit_cnt_r;
   logic [BW-1:0]    bit_cnt_nx_s;
   logic             x_in_r;
   logic             x_in_nx_s;
   logic             busy_r;
   logic             busy_nx_s;
   logic             done_r;
   logic             done_nx_s;
   logic             hold_start_s;
   logic             hold_expired_s;
   logic             last_cycle_s;
   logic             accept_s;

   bit_hold_counter #(
      .HOLD (HOLD)
   ) u_hold (
      .clock   (clock),
      .reset   (reset),
      .start   (hold_start_s),
      .expired (hold_expired_s)
   );

   assign last_cycle_s = (state_r == ST_SHIFT) && hold_expired_s && (bit_cnt_r == LAST_BIT);
   assign load_ready   = (state_r == ST_IDLE) || last_cycle_s;
   assign accept_s     = load_valid && load_ready;

   // next-state decode: a load in the final hold cycle chains straight into the new pattern
   always_comb begin
      state_nx_s   = state_r;
      shift_nx_s   = shift_r;
      bit_cnt_nx_s = bit_cnt_r;
      x_in_nx_s    = x_in_r;
      busy_nx_s    = busy_r;
      done_nx_s    = 1'b0;
      hold_start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s   = ST_SHIFT;
               shift_nx_s   = load_data;
               bit_cnt_nx_s = '0;
               hold_start_s = 1'b1;
               x_in_nx_s    = load_data[WIDTH-1];
               busy_nx_s    = 1'b1;
            end else begin
               x_in_nx_s    = 1'b0;
               busy_nx_s    = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (last_cycle_s) begin
               done_nx_s = 1'b1;
               if (accept_s) begin
                  state_nx_s   = ST_SHIFT;
                  shift_nx_s   = load_data;
                  bit_cnt_nx_s = '0;
                  hold_start_s = 1'b1;
                  x_in_nx_s    = load_data[WIDTH-1];
                  busy_nx_s    = 1'b1;
               end else begin
                  state_nx_s   = ST_IDLE;
                  shift_nx_s   = '0;
                  bit_cnt_nx_s = '0;
                  x_in_nx_s    = 1'b0;
                  busy_nx_s    = 1'b0;
               end
            end else if (hold_expired_s) begin
               shift_nx_s   = {shift_r[WIDTH-2:0], 1'b0};
               bit_cnt_nx_s = bit_cnt_r + BIT_ONE;
               hold_start_s = 1'b1;
               x_in_nx_s    = shift_r[WIDTH-2];
               busy_nx_s    = 1'b1;
            end else begin
               busy_nx_s    = 1'b1;
            end
         end
         default: begin
            state_nx_s   = ST_IDLE;
            shift_nx_s   = '0;
            bit_cnt_nx_s = '0;
            x_in_nx_s    = 1'b0;
            busy_nx_s    = 1'b0;
         end
      endcase
   end

   // state and registered outputs; reset abandons any pattern without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= '0;
         bit_cnt_r <= '0;
         x_in_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         shift_r   <= shift_nx_s;
         bit_cnt_r <= bit_cnt_nx_s;
         x_in_r    <= x_in_nx_s;
         busy_r    <= busy_nx_s;
         done_r    <= done_nx_s;
      end
   end

   assign x_in = x_in_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_x_in_serializer.sv
// Directed bench for x_in_serializer: a pattern-level reference model checked every
// cycle, plus hand-computed waveform expectations for the listed scenarios.
module tb_x_in_serializer;

   localparam int W = 8;
   localparam int H = 3;
   localparam int N = W * H;

   logic         clock;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         x_in;
   logic         busy;
   logic         done;

   logic         lv1;
   logic [W-1:0] ld1;
   logic         rdy1;
   logic         x1;
   logic         busy1;
   logic         done1;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // reference model state: pattern in flight and how many of its cycles have elapsed
   bit           m_active = 1'b0;
   int           m_k      = 0;
   logic [W-1:0] m_pat    = '0;
   bit           m_done   = 1'b0;

   x_in_serializer #(.WIDTH(W), .HOLD(H)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .x_in       (x_in),
      .busy       (busy),
      .done       (done)
   );

   x_in_serializer #(.WIDTH(W), .HOLD(1)) dut1 (
      .clock      (clock),
      .reset      (reset),
      .load_valid (lv1),
      .load_data  (ld1),
      .load_ready (rdy1),
      .x_in       (x1),
      .busy       (busy1),
      .done       (done1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // model update: each pattern occupies N cycles; done follows its last cycle
   always @(posedge clock) begin
      bit rdy;
      bit fin;
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         m_done   = 1'b0;
      end else begin
         rdy = !m_active || (m_k == N - 1);
         fin = m_active && (m_k == N - 1);
         if (load_valid && rdy) begin
            m_active = 1'b1;
            m_k      = 0;
            m_pat    = load_data;
         end else if (m_active) begin
            if (m_k == N - 1) m_active = 1'b0;
            else m_k = m_k + 1;
         end
         m_done = fin;
      end
   end

   // compare process
   always @(negedge clock) begin
      if (chk_en) begin
         check("model x_in", {63'd0, x_in}, {63'd0, m_active ? m_pat[W - 1 - m_k / H] : 1'b0});
         check("model busy", {63'd0, busy}, {63'd0, m_active});
         check("model done", {63'd0, done}, {63'd0, m_done});
         check("model load_ready", {63'd0, load_ready}, {63'd0, (!m_active || m_k == N - 1)});
      end
   end

   // Called at the negedge of cycle 1 of a pattern; records n cycles of the main DUT.
   task automatic record(input int n, input int on_c, input int off_c, input logic [W-1:0] d,
                         output logic [63:0] xs, output logic [63:0] dm,
                         output int bc, output int rc);
      xs = '0;
      dm = '0;
      bc = 0;
      rc = 0;
      for (int c = 1; c <= n; c++) begin
         xs    = {xs[62:0], x_in};
         dm[c] = done;
         if (busy) bc++;
         if (load_valid && load_ready) rc++;
         if (c == off_c) load_valid = 1'b0;
         if (c == on_c) begin
            load_valid = 1'b1;
            load_data  = d;
         end
         if (c < n) @(negedge clock);
      end
   endtask

   task automatic start_pattern(input logic [W-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clock);
   endtask

   initial begin
      logic [63:0] xs;
      logic [63:0] dm;
      int          bc;
      int          rc;

      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      lv1        = 1'b0;
      ld1        = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset x_in", {63'd0, x_in}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset load_ready", {63'd0, load_ready}, 64'd1);
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clock);

      // single load 8'hA5
      start_pattern(8'hA5);
      record(26, 0, 1, 8'h00, xs, dm, bc, rc);
      check("A5 waveform", {40'd0, xs[25:2]}, 64'h0000_0000_00E3_81C7);
      check("A5 busy cycles", 64'(bc), 64'd24);
      check("A5 done cycle", dm, 64'h0000_0000_0200_0000);
      repeat (3) @(negedge clock);

      // back-to-back 8'hFF then 8'h00 held valid
      start_pattern(8'hFF);
      record(50, 1, 25, 8'h00, xs, dm, bc, rc);
      check("b2b busy cycles", 64'(bc), 64'd48);
      check("b2b done cycles", dm, 64'h0002_0000_0200_0000);
      check("b2b acceptances", 64'(rc), 64'd1);
      check("b2b waveform", {14'd0, xs[49:0]}, {14'd0, 24'hFFFFFF, 26'd0});
      repeat (3) @(negedge clock);

      // backpressure: 8'h3C offered during cycles 2..10 of 8'h96
      start_pattern(8'h96);
      record(26, 2, 11, 8'h3C, xs, dm, bc, rc);
      check("bp acceptances", 64'(rc), 64'd0);
      check("bp waveform", {40'd0, xs[25:2]}, 64'h0000_0000_00E0_71F8);
      check("bp done cycle", dm, 64'h0000_0000_0200_0000);
      check("bp busy cycles", 64'(bc), 64'd24);
      repeat (3) @(negedge clock);

      // reset mid-pattern at cycle 10 of 8'hF0, with a competing load
      start_pattern(8'hF0);
      load_valid = 1'b0;
      repeat (9) @(negedge clock);
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(negedge clock);
      reset      = 1'b0;
      load_valid = 1'b0;
      check("abort x_in", {63'd0, x_in}, 64'd0);
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort load_ready", {63'd0, load_ready}, 64'd1);
      record(20, 0, 0, 8'h00, xs, dm, bc, rc);
      check("abort no done", dm, 64'd0);
      check("abort stays idle", 64'(bc), 64'd0);

      // reset beats a simultaneous load while idle
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(negedge clock);
      reset      = 1'b0;
      load_valid = 1'b0;
      check("reset priority busy", {63'd0, busy}, 64'd0);
      check("reset priority x_in", {63'd0, x_in}, 64'd0);
      @(negedge clock);
      check("reset priority stays idle", {63'd0, busy}, 64'd0);

      // HOLD = 1 instance: 8'h81
      lv1 = 1'b1;
      ld1 = 8'h81;
      @(negedge clock);
      lv1 = 1'b0;
      xs  = '0;
      dm  = '0;
      bc  = 0;
      for (int c = 1; c <= 10; c++) begin
         xs    = {xs[62:0], x1};
         dm[c] = done1;
         if (busy1) bc++;
         if (c < 10) @(negedge clock);
      end
      check("hold1 waveform", {54'd0, xs[9:0]}, 64'h204);
      check("hold1 done cycle", dm, 64'h200);
      check("hold1 busy cycles", 64'(bc), 64'd8);
      check("hold1 ready after", {63'd0, rdy1}, 64'd1);

      @(negedge clock);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
